imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 138 +++++++++++++
 tb/tb_imem_loader.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles little-endian bytes into words and writes them from BASE_ADDR upward.
// Optional running word checksum is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int                AWIDTH    = 32,
    parameter int                DWIDTH    = 32,
    parameter logic [AWIDTH-1:0] BASE_ADDR = 32'h0100_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [15:0]       len_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_i,
    output logic              byte_ready_o,
    output logic [AWIDTH-1:0] addr_o,
    output logic [DWIDTH-1:0] data_o,
    output logic              write_en_o,
    output logic              read_en_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [31:0]       checksum_o
);

    localparam int NBYTES = DWIDTH / 8;
    localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0]     LAST_IDX  = IW'(NBYTES - 1);
    localparam logic [AWIDTH-1:0] ADDR_STEP = AWIDTH'(NBYTES);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] WRITE   = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    logic [1:0]        state;
    logic [15:0]       len_q;
    logic [15:0]       word_cnt;
    logic [IW-1:0]     byte_idx;
    logic [DWIDTH-1:0] word_asm;
    logic [DWIDTH-1:0] word_next;
    logic [AWIDTH-1:0] wr_addr;
    logic              last_word;
    logic              load_start;

    always_comb begin
        word_next = word_asm;
        word_next[8*byte_idx +: 8] = byte_i;
    end

    assign last_word  = (word_cnt == len_q - 16'd1);
    assign load_start = (state == IDLE) && start_i && (len_i != 16'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            len_q    <= '0;
            word_cnt <= '0;
            byte_idx <= '0;
            word_asm <= '0;
            wr_addr  <= '0;
            addr_o   <= '0;
            data_o   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        if (len_i != 16'd0) begin
                            state    <= COLLECT;
                            len_q    <= len_i;
                            word_cnt <= '0;
                            byte_idx <= '0;
                            wr_addr  <= BASE_ADDR;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                COLLECT: begin
                    if (byte_valid_i) begin
                        word_asm <= word_next;
                        if (byte_idx == LAST_IDX) begin
                            // addr/data are only updated here so they hold outside WRITE
                            data_o <= word_next;
                            addr_o <= wr_addr;
                            state  <= WRITE;
                        end else begin
                            byte_idx <= byte_idx + IW'(1);
                        end
                    end
                end
                WRITE: begin
                    if (last_word) begin
                        state <= DONE;
                    end else begin
                        word_cnt <= word_cnt + 16'd1;
                        byte_idx <= '0;
                        wr_addr  <= wr_addr + ADDR_STEP;
                        state    <= COLLECT;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign byte_ready_o = (state == COLLECT);
    assign write_en_o   = (state == WRITE);
    assign read_en_o    = 1'b0;
    assign busy_o       = (state != IDLE);
    assign done_o       = (state == DONE);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam int LW = (DWIDTH < 32) ? DWIDTH : 32;

    logic [31:0] checksum_q;
    logic [31:0] word_low;

    always_comb begin
        word_low         = '0;
        word_low[LW-1:0] = data_o[LW-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum_q <= '0;
        end else if (load_start) begin
            checksum_q <= '0;
        end else if (state == WRITE) begin
            checksum_q <= checksum_q + word_low;
        end
    end

    assign checksum_o = checksum_q;
`else
    assign checksum_o = '0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized bench for imem_loader against a word-list reference model.
// Checksum expectations follow IMEM_LOADER_CHECKSUM_EN when it is defined for the build.
module tb_imem_loader;

    localparam logic [31:0] BASE = 32'h0100_0000;
    localparam int BUDGET = 2000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [15:0] len_i;
    logic        byte_valid_i;
    logic [7:0]  byte_i;
    logic        byte_ready_o;
    logic [31:0] addr_o;
    logic [31:0] data_o;
    logic        write_en_o;
    logic        read_en_o;
    logic        busy_o;
    logic        done_o;
    logic [31:0] checksum_o;

    imem_loader dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .len_i       (len_i),
        .byte_valid_i(byte_valid_i),
        .byte_i      (byte_i),
        .byte_ready_o(byte_ready_o),
        .addr_o      (addr_o),
        .data_o      (data_o),
        .write_en_o  (write_en_o),
        .read_en_o   (read_en_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .checksum_o  (checksum_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed memory writes, stamped with the edge that commits them
    logic [31:0] w_addr[$];
    logic [31:0] w_data[$];
    int          w_edge[$];
    int          done_cnt  = 0;
    int          done_edge = 0;
    int          hold_err  = 0;
    int          ovl_err   = 0;
    int          rd_err    = 0;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_data = '0;

    always @(negedge clk) begin
        if (write_en_o === 1'b1) begin
            w_addr.push_back(addr_o);
            w_data.push_back(data_o);
            w_edge.push_back(cyc + 1);
        end
        if (done_o === 1'b1) begin
            done_cnt  <= done_cnt + 1;
            done_edge <= cyc + 1;
        end
        if (rst === 1'b0 && write_en_o !== 1'b1 && (addr_o !== prev_addr || data_o !== prev_data))
            hold_err <= hold_err + 1;
        if (write_en_o === 1'b1 && byte_ready_o === 1'b1) ovl_err <= ovl_err + 1;
        if (read_en_o !== 1'b0) rd_err <= rd_err + 1;
        prev_addr <= addr_o;
        prev_data <= data_o;
    end

    int n_assert = 0;
    int n_fail   = 0;
    int stall_bad = 0;
    logic [31:0] exp_words[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_checksum();
        logic [31:0] s = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        foreach (exp_words[i]) s = s + exp_words[i];
`endif
        return s;
    endfunction

    // Feeds exp_words as little-endian bytes; valid is high with probability pct,
    // and held low for stall_len cycles once stall_at bytes have been accepted
    task automatic drive_load(input int len, input int pct, input int stall_at, input int stall_len,
                              output int s_cyc, output int tmo);
        int bi = 0;
        int sc = 0;
        int budget = 0;
        int nb = len * 4;
        logic v;
        logic [31:0] w;
        w_addr.delete();
        w_data.delete();
        w_edge.delete();
        start_i = 1'b1;
        len_i   = 16'(len);
        @(negedge clk);
        start_i = 1'b0;
        len_i   = 16'($urandom);
        s_cyc   = cyc;
        while (bi < nb && budget < BUDGET) begin
            if (bi == stall_at && sc < stall_len) begin
                v = 1'b0;
                sc++;
                start_i = 1'b1;
                len_i   = 16'd9;
                if (byte_ready_o !== 1'b1) stall_bad++;
            end else begin
                start_i = 1'b0;
                v = ($urandom_range(0, 99) < pct);
            end
            w = exp_words[bi / 4];
            byte_valid_i = v;
            byte_i = v ? w[8*(bi % 4) +: 8] : 8'($urandom);
            if (v && byte_ready_o === 1'b1) bi++;
            @(negedge clk);
            budget++;
        end
        start_i      = 1'b0;
        byte_valid_i = 1'b0;
        while (busy_o !== 1'b0 && budget < BUDGET) begin
            @(negedge clk);
            budget++;
        end
        tmo = (budget >= BUDGET) ? 1 : 0;
    endtask

    task automatic check_load(input string tag, input int len, input int s_cyc, input int tmo,
                              input int done_base, input int first_lat, input int last_lat);
        int n;
        chk({tag, "_timeout"}, 64'(tmo), 64'd0);
        chk({tag, "_nwrites"}, 64'(w_addr.size()), 64'(len));
        n = (w_addr.size() < len) ? w_addr.size() : len;
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_addr%0d", tag, i), 64'(w_addr[i]), 64'(BASE + 32'(4 * i)));
            chk($sformatf("%s_data%0d", tag, i), 64'(w_data[i]), 64'(exp_words[i]));
        end
        chk({tag, "_done_cnt"}, 64'(done_cnt - done_base), 64'd1);
        if (n > 0) begin
            chk({tag, "_done_after_write"}, 64'(done_edge), 64'(w_edge[n-1] + 1));
            if (first_lat >= 0) chk({tag, "_first_lat"}, 64'(w_edge[0] - s_cyc), 64'(first_lat));
            if (last_lat >= 0)  chk({tag, "_last_lat"}, 64'(w_edge[n-1] - s_cyc), 64'(last_lat));
        end
        chk({tag, "_checksum"}, 64'(checksum_o), 64'(model_checksum()));
    endtask

    initial begin
        int s_cyc;
        int tmo;
        int dbase;
        int len;
        logic [31:0] w;

        rst = 1'b1;
        start_i = 1'b0;
        len_i = '0;
        byte_valid_i = 1'b0;
        byte_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_ready", 64'(byte_ready_o), 64'd0);
        chk("rst_we", 64'(write_en_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_addr", 64'(addr_o), 64'd0);
        chk("rst_data", 64'(data_o), 64'd0);
        chk("rst_checksum", 64'(checksum_o), 64'd0);
        #2 rst = 1'b0;
        @(negedge clk);

        // single word, continuous bytes
        exp_words = '{32'h0000_0013};
        dbase = done_cnt;
        drive_load(1, 100, -1, 0, s_cyc, tmo);
        check_load("len1", 1, s_cyc, tmo, dbase, 5, 5);

        // three words, continuous bytes
        exp_words = '{$urandom, $urandom, $urandom};
        dbase = done_cnt;
        drive_load(3, 100, -1, 0, s_cyc, tmo);
        check_load("len3", 3, s_cyc, tmo, dbase, 5, 15);

        // valid low for 7 cycles after the second byte, with a start_i pulse that must be ignored
        exp_words = '{$urandom};
        dbase = done_cnt;
        drive_load(1, 100, 2, 7, s_cyc, tmo);
        check_load("stall", 1, s_cyc, tmo, dbase, 12, 12);
        chk("stall_ready_low", 64'(stall_bad), 64'd0);

        // zero-length load
        w_addr.delete();
        dbase = done_cnt;
        start_i = 1'b1;
        len_i = 16'd0;
        @(negedge clk);
        start_i = 1'b0;
        chk("len0_done", 64'(done_o), 64'd1);
        chk("len0_we", 64'(write_en_o), 64'd0);
        @(negedge clk);
        chk("len0_done_clear", 64'(done_o), 64'd0);
        chk("len0_busy", 64'(busy_o), 64'd0);
        chk("len0_nwrites", 64'(w_addr.size()), 64'd0);
        chk("len0_done_cnt", 64'(done_cnt - dbase), 64'd1);

        // reset after two bytes of a word
        w = 32'hA5C3_7E19;
        w_addr.delete();
        start_i = 1'b1;
        len_i = 16'd1;
        @(negedge clk);
        start_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            byte_valid_i = 1'b1;
            byte_i = w[8*k +: 8];
            @(negedge clk);
        end
        #2 rst = 1'b1;
        byte_valid_i = 1'b0;
        #1;
        chk("abort_busy", 64'(busy_o), 64'd0);
        chk("abort_ready", 64'(byte_ready_o), 64'd0);
        chk("abort_we", 64'(write_en_o), 64'd0);
        chk("abort_done", 64'(done_o), 64'd0);
        chk("abort_addr", 64'(addr_o), 64'd0);
        chk("abort_data", 64'(data_o), 64'd0);
        chk("abort_checksum", 64'(checksum_o), 64'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_nwrites", 64'(w_addr.size()), 64'd0);
        exp_words = '{32'h0BAD_F00D};
        dbase = done_cnt;
        drive_load(1, 100, -1, 0, s_cyc, tmo);
        check_load("after_abort", 1, s_cyc, tmo, dbase, 5, 5);

        // checksum wrap
        exp_words = '{32'hFFFF_FFFF, 32'h0000_0002};
        dbase = done_cnt;
        drive_load(2, 100, -1, 0, s_cyc, tmo);
        check_load("cksum", 2, s_cyc, tmo, dbase, 5, 10);

        // random lengths, data and valid gaps
        for (int t = 0; t < 5; t++) begin
            len = $urandom_range(1, 6);
            exp_words.delete();
            for (int i = 0; i < len; i++) exp_words.push_back($urandom);
            dbase = done_cnt;
            drive_load(len, 60, -1, 0, s_cyc, tmo);
            check_load($sformatf("rand%0d", t), len, s_cyc, tmo, dbase, -1, -1);
        end

        @(negedge clk);
        chk("addr_data_hold", 64'(hold_err), 64'd0);
        chk("we_ready_exclusive", 64'(ovl_err), 64'd0);
        chk("read_en_zero", 64'(rd_err), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
